fp_div_issue: RTL and testbench
===============================

Name: fp_div_issue

Overview:
Issue-side companion to the iterative FP divide/sqrt unit. Buffers div/sqrt ops from dispatch in a small in-order queue and launches one op at a time with a single-cycle start pulse, only while the unit is idle. Captures the unit's one-cycle valid result, with its ROB and destination tags, into a writeback slot that drains over a valid/ready handshake. Handles pipeline flush, including discarding an op already in flight.

Parameters:
W, 32, operand width (32 single, 64 double)
LG_DEPTH, 2, log2 of queue entries (4)
LG_ROB_WIDTH, 1, ROB pointer width
LG_PRF_WIDTH, 1, physical register pointer width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset (asserted at 0)
enq_valid  in  1  dispatch offers an op
enq_ready  out  1  queue can accept (= !full)
enq_a  in  W  dividend / sqrt operand
enq_b  in  W  divisor
enq_is_sqrt  in  1  op is sqrt
enq_rob_ptr  in  LG_ROB_WIDTH  ROB tag
enq_dst_ptr  in  LG_PRF_WIDTH  destination PRF tag
flush  in  1  squash all queued and in-flight ops
fu_start  out  1  one-cycle launch pulse to divider
fu_a, fu_b  out  W  operands of launched op
fu_is_sqrt  out  1  sqrt flag of launched op
fu_rob_ptr  out  LG_ROB_WIDTH  tag of launched op
fu_dst_ptr  out  LG_PRF_WIDTH  tag of launched op
fu_active  in  1  divider busy
fu_valid  in  1  divider result pulse
fu_y  in  W  divider result
fu_rob_ptr_out  in  LG_ROB_WIDTH  returned ROB tag
fu_dst_ptr_out  in  LG_PRF_WIDTH  returned PRF tag
wb_valid  out  1  writeback slot full
wb_ready  in  1  writeback consumer accepts
wb_y  out  W  result
wb_rob_ptr  out  LG_ROB_WIDTH  result ROB tag
wb_dst_ptr  out  LG_PRF_WIDTH  result PRF tag
busy  out  1  queue non-empty, op in flight, or wb_valid

Behaviour:
- Reset (reset==0, async) clears all of the following, and they stay cleared until reset deasserts: queue pointers and count, state=IDLE, kill flag, wb slot. Output reset values: wb_valid=0, fu_start=0, enq_ready=1, busy=0, wb_y/wb_rob_ptr/wb_dst_ptr=0.
- Queue: circular buffer of 2^LG_DEPTH entries with read/write pointers and a count of LG_DEPTH+1 bits.
  - Pointers wrap modulo depth.
  - Push when enq_valid&&enq_ready. There is no bypass when full.
  - Push and pop in the same cycle leave the count unchanged.
- fu_a/b/is_sqrt/rob/dst always present the queue head entry.
- FSM states: IDLE, WAIT.
  - IDLE: fu_start = !empty && !fu_active && !wb_valid && !flush (combinational). When fu_start is asserted, pop the head and go to WAIT.
  - WAIT: on fu_valid, go to IDLE. If kill==0, load fu_y/fu_rob_ptr_out/fu_dst_ptr_out into the wb slot and set wb_valid. If kill==1, drop the result. Clear kill in both cases.
  - IDLE also blocks while fu_active=1: the divider holds active one cycle past its valid pulse.
- Minimum latency: push at cycle t gives fu_start at t+1.
- Single launch in flight: the next launch requires wb_valid=0, because the divider has no backpressure.
- wb slot: wb_valid holds, with stable data, until wb_valid&&wb_ready. wb_valid and fu_valid cannot coincide because launch is gated on an empty slot.
- flush (single cycle):
  - Empties the queue (count=0, rd=wr).
  - Clears wb_valid.
  - Blocks fu_start that cycle.
  - A push offered in the same cycle is dropped.
  - In WAIT, sets kill=1. If fu_valid arrives in the same cycle as flush, that result is dropped.
- A flush while IDLE with nothing in flight has no effect beyond clearing the queue.

Decomposition:
- A shared FP package holds the state enum {IDLE, WAIT} and the FW/EW localparam derivation by W.
- Natural sub-module: fp_div_issue_q, the parametric FIFO carrying a packed entry {a, b, is_sqrt, rob, dst}. The FSM, kill flag and wb slot stay in the top module.

Test Plan:
- Single op: push a=0x3F800000, b=0x40000000, rob=1, dst=1 at t0 -> fu_start at t1 with those operands. fu model returns y=0x3F000000 -> wb_valid with wb_y=0x3F000000, rob=1, dst=1, held until wb_ready.
- Back-to-back: push 4 ops (rob 0..3) then a 5th -> enq_ready=0 while full. Results leave in order 0..3. Each fu_start occurs only after fu_active=0 and the wb slot drains.
- Wb backpressure: hold wb_ready=0 for 10 cycles after a result -> no fu_start, wb data stable. Raise wb_ready -> next launch on the following cycle.
- Flush in flight: launch rob=2, flush at the next cycle, fu_valid arrives later -> wb_valid stays 0, queue empty, busy falls after the result is dropped.
- Flush coincident: flush in the same cycle as enq_valid and fu_valid -> no push, no wb capture, kill clear afterwards.
- Reset mid-op: drive reset=0 while in WAIT with 3 entries queued -> all outputs at reset values immediately. Normal single-op behaviour resumes after release.

Source files
------------

// File: rtl/fp_div_issue_pkg.sv
// Shared definitions for the FP divide/sqrt issue slice: launch FSM states and
// exponent/fraction width derivation from the operand width.
package fp_div_issue_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic int fp_ew(input int w);
        return (w == 32'sd64) ? 32'sd11 : 32'sd8;
    endfunction

    function automatic int fp_fw(input int w);
        return (w == 32'sd64) ? 32'sd52 : 32'sd23;
    endfunction

endpackage

// File: rtl/fp_div_issue_q.sv
// In-order circular buffer holding packed div/sqrt ops awaiting launch.
module fp_div_issue_q
    import fp_div_issue_pkg::*;
#(
    parameter int DW       = 8,
    parameter int LG_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          empty,
    output logic          full
);

    localparam int DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] DEPTH_C = {1'b1, {LG_DEPTH{1'b0}}};

    logic [DW-1:0]       mem_r [DEPTH];
    logic [LG_DEPTH-1:0] rd_ptr_r;
    logic [LG_DEPTH-1:0] wr_ptr_r;
    logic [LG_DEPTH:0]   count_r;

    assign dout  = mem_r[rd_ptr_r];
    assign empty = (count_r == {(LG_DEPTH+1){1'b0}});
    assign full  = (count_r == DEPTH_C);

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; clear discards everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= {LG_DEPTH{1'b0}};
            wr_ptr_r <= {LG_DEPTH{1'b0}};
            count_r  <= {(LG_DEPTH+1){1'b0}};
        end else if (clear) begin
            rd_ptr_r <= {LG_DEPTH{1'b0}};
            wr_ptr_r <= {LG_DEPTH{1'b0}};
            count_r  <= {(LG_DEPTH+1){1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + LG_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + LG_DEPTH'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + (LG_DEPTH+1)'(1);
                2'b01:   count_r <= count_r - (LG_DEPTH+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fp_div_issue.sv
// Issue stage for the iterative FP divide/sqrt unit: queues ops, launches one at a
// time, captures the tagged result into a writeback slot, and squashes on flush.
module fp_div_issue
    import fp_div_issue_pkg::*;
#(
    parameter int W            = 32,
    parameter int LG_DEPTH     = 2,
    parameter int LG_ROB_WIDTH = 1,
    parameter int LG_PRF_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [W-1:0]            enq_a,
    input  logic [W-1:0]            enq_b,
    input  logic                    enq_is_sqrt,
    input  logic [LG_ROB_WIDTH-1:0] enq_rob_ptr,
    input  logic [LG_PRF_WIDTH-1:0] enq_dst_ptr,
    input  logic                    flush,
    output logic                    fu_start,
    output logic [W-1:0]            fu_a,
    output logic [W-1:0]            fu_b,
    output logic                    fu_is_sqrt,
    output logic [LG_ROB_WIDTH-1:0] fu_rob_ptr,
    output logic [LG_PRF_WIDTH-1:0] fu_dst_ptr,
    input  logic                    fu_active,
    input  logic                    fu_valid,
    input  logic [W-1:0]            fu_y,
    input  logic [LG_ROB_WIDTH-1:0] fu_rob_ptr_out,
    input  logic [LG_PRF_WIDTH-1:0] fu_dst_ptr_out,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [W-1:0]            wb_y,
    output logic [LG_ROB_WIDTH-1:0] wb_rob_ptr,
    output logic [LG_PRF_WIDTH-1:0] wb_dst_ptr,
    output logic                    busy
);

    localparam int EW = 2 * W + 1 + LG_ROB_WIDTH + LG_PRF_WIDTH;

    state_t                  state_r;
    logic                    kill_r;
    logic                    wb_valid_r;
    logic [W-1:0]            wb_y_r;
    logic [LG_ROB_WIDTH-1:0] wb_rob_r;
    logic [LG_PRF_WIDTH-1:0] wb_dst_r;

    logic                    q_empty_s;
    logic                    q_full_s;
    logic                    push_s;
    logic                    start_s;
    logic [EW-1:0]           head_s;

    assign push_s  = enq_valid && !q_full_s && !flush;
    // The divider cannot stall its result, so a launch waits for an empty wb slot.
    assign start_s = (state_r == IDLE) && !q_empty_s && !fu_active && !wb_valid_r && !flush;

    fp_div_issue_q #(
        .DW       (EW),
        .LG_DEPTH (LG_DEPTH)
    ) u_q (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (start_s),
        .clear (flush),
        .din   ({enq_a, enq_b, enq_is_sqrt, enq_rob_ptr, enq_dst_ptr}),
        .dout  (head_s),
        .empty (q_empty_s),
        .full  (q_full_s)
    );

    assign {fu_a, fu_b, fu_is_sqrt, fu_rob_ptr, fu_dst_ptr} = head_s;

    assign fu_start   = start_s;
    assign enq_ready  = !q_full_s;
    assign wb_valid   = wb_valid_r;
    assign wb_y       = wb_y_r;
    assign wb_rob_ptr = wb_rob_r;
    assign wb_dst_ptr = wb_dst_r;
    assign busy       = !q_empty_s || (state_r == WAIT) || wb_valid_r;

    // Launch FSM with the kill flag that marks the in-flight op as squashed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            kill_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    kill_r <= 1'b0;
                    if (start_s) begin
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (fu_valid) begin
                        state_r <= IDLE;
                        kill_r  <= 1'b0;
                    end else if (flush) begin
                        kill_r  <= 1'b1;
                    end else begin
                        kill_r  <= kill_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    kill_r  <= 1'b0;
                end
            endcase
        end
    end

    // Writeback slot: a flush, including one coincident with the result, drops it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_valid_r <= 1'b0;
            wb_y_r     <= {W{1'b0}};
            wb_rob_r   <= {LG_ROB_WIDTH{1'b0}};
            wb_dst_r   <= {LG_PRF_WIDTH{1'b0}};
        end else if (flush) begin
            wb_valid_r <= 1'b0;
        end else if ((state_r == WAIT) && fu_valid && !kill_r) begin
            wb_valid_r <= 1'b1;
            wb_y_r     <= fu_y;
            wb_rob_r   <= fu_rob_ptr_out;
            wb_dst_r   <= fu_dst_ptr_out;
        end else if (wb_valid_r && wb_ready) begin
            wb_valid_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_div_issue.sv
// Scoreboard bench for fp_div_issue with a small latency model of the divider.
module tb_fp_div_issue;

    localparam int W   = 32;
    localparam int LR  = 2;
    localparam int LP  = 2;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [W-1:0]  enq_a = '0;
    logic [W-1:0]  enq_b = '0;
    logic          enq_is_sqrt = 1'b0;
    logic [LR-1:0] enq_rob_ptr = '0;
    logic [LP-1:0] enq_dst_ptr = '0;
    logic          flush = 1'b0;
    logic          fu_start;
    logic [W-1:0]  fu_a, fu_b;
    logic          fu_is_sqrt;
    logic [LR-1:0] fu_rob_ptr;
    logic [LP-1:0] fu_dst_ptr;
    logic          fu_active;
    logic          fu_valid;
    logic [W-1:0]  fu_y;
    logic [LR-1:0] fu_rob_ptr_out;
    logic [LP-1:0] fu_dst_ptr_out;
    logic          wb_valid;
    logic          wb_ready = 1'b1;
    logic [W-1:0]  wb_y;
    logic [LR-1:0] wb_rob_ptr;
    logic [LP-1:0] wb_dst_ptr;
    logic          busy;

    always #5 clk = ~clk;

    fp_div_issue #(.W(W), .LG_DEPTH(2), .LG_ROB_WIDTH(LR), .LG_PRF_WIDTH(LP)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_a(enq_a), .enq_b(enq_b),
        .enq_is_sqrt(enq_is_sqrt), .enq_rob_ptr(enq_rob_ptr), .enq_dst_ptr(enq_dst_ptr),
        .flush(flush),
        .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_is_sqrt(fu_is_sqrt),
        .fu_rob_ptr(fu_rob_ptr), .fu_dst_ptr(fu_dst_ptr),
        .fu_active(fu_active), .fu_valid(fu_valid), .fu_y(fu_y),
        .fu_rob_ptr_out(fu_rob_ptr_out), .fu_dst_ptr_out(fu_dst_ptr_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_y(wb_y),
        .wb_rob_ptr(wb_rob_ptr), .wb_dst_ptr(wb_dst_ptr), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] a; logic [31:0] b; logic s; logic [1:0] rob; logic [1:0] dst; } launch_t;
    typedef struct { logic [31:0] y; logic [1:0] rob; logic [1:0] dst; } res_t;
    launch_t launch_q[$];
    res_t    res_q[$];
    launch_t le;
    res_t    re;

    // Divider stand-in: fixed latency, busy from launch until one cycle past valid.
    logic        hold_active = 1'b0;
    logic        m_busy, m_active;
    int          m_cnt, m_tail;
    logic [31:0] m_y;
    logic [1:0]  m_rob, m_dst;

    function automatic logic [31:0] fu_func(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (s) begin
            case (a)
                32'h40800000: return 32'h40000000;
                32'h41100000: return 32'h40400000;
                default:      return 32'hDEADBEEF;
            endcase
        end
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h3F000000;
            {32'h40800000, 32'h40000000}: return 32'h40000000;
            {32'h41000000, 32'h40000000}: return 32'h40800000;
            {32'h40000000, 32'h3F800000}: return 32'h40000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    assign fu_active = m_active | hold_active;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_active <= 1'b0; m_cnt <= 0; m_tail <= 0;
            m_y <= '0; m_rob <= '0; m_dst <= '0;
            fu_valid <= 1'b0; fu_y <= '0; fu_rob_ptr_out <= '0; fu_dst_ptr_out <= '0;
        end else begin
            fu_valid <= 1'b0;
            if (fu_start) begin
                m_busy <= 1'b1; m_active <= 1'b1; m_cnt <= LAT;
                m_y <= fu_func(fu_a, fu_b, fu_is_sqrt); m_rob <= fu_rob_ptr; m_dst <= fu_dst_ptr;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    fu_valid <= 1'b1; fu_y <= m_y; fu_rob_ptr_out <= m_rob; fu_dst_ptr_out <= m_dst;
                    m_busy <= 1'b0; m_tail <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (m_tail > 0) begin
                m_tail <= m_tail - 1;
                if (m_tail == 1) m_active <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every launch and every drained result is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (fu_start) begin
                chk("start_gate", {62'd0, fu_active, wb_valid}, 64'd0);
                if (launch_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL launch_unexpected: got rob %0d expected none", fu_rob_ptr);
                end else begin
                    le = launch_q.pop_front();
                    chk("launch_ops", {fu_a, fu_b}, {le.a, le.b});
                    chk("launch_tag", {59'd0, fu_is_sqrt, fu_rob_ptr, fu_dst_ptr}, {59'd0, le.s, le.rob, le.dst});
                end
            end
            if (wb_valid && wb_ready) begin
                if (res_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: got y %0h expected none", wb_y);
                end else begin
                    re = res_q.pop_front();
                    chk("wb_result", {28'd0, wb_y, wb_rob_ptr, wb_dst_ptr}, {28'd0, re.y, re.rob, re.dst});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [1:0] rob, input logic [1:0] dst,
                        input bit exp_launch, input bit exp_res, input logic [31:0] y);
        int n = 0;
        enq_valid = 1'b1; enq_a = a; enq_b = b; enq_is_sqrt = s; enq_rob_ptr = rob; enq_dst_ptr = dst;
        while (!enq_ready && n < 200) begin
            tick();
            n++;
        end
        if (!enq_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout: enq_ready 0 expected 1");
        end else begin
            if (exp_launch) launch_q.push_back('{a, b, s, rob, dst});
            if (exp_res) res_q.push_back('{y, rob, dst});
        end
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || fu_active) && n < 300) begin
            tick();
            n++;
        end
        if (busy || fu_active) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy %0b expected 0", busy);
        end
    endtask

    task automatic wait_sig(input string name, input bit want_wb);
        int n = 0;
        while (!(want_wb ? wb_valid : fu_valid) && n < 100) begin
            tick();
            n++;
        end
        if (!(want_wb ? wb_valid : fu_valid)) begin
            checks++; errors++;
            $display("FAIL %s: got 0 expected 1", name);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, "_fu_start"}, {63'd0, fu_start}, 64'd0);
        chk({tag, "_enq_ready"}, {63'd0, enq_ready}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_wb_data"}, {28'd0, wb_y, wb_rob_ptr, wb_dst_ptr}, 64'd0);
    endtask

    initial begin
        #3;
        reset_checks("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        tick();

        // Single op with push-to-start latency of one cycle and a held wb slot.
        wb_ready = 1'b0;
        push(32'h3F800000, 32'h40000000, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'h3F000000);
        chk("single_latency", {63'd0, fu_start}, 64'd1);
        wait_sig("single_wb_wait", 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("single_hold", {27'd0, wb_valid, wb_y, wb_rob_ptr, wb_dst_ptr}, {27'd1, 32'h3F000000, 2'd1, 2'd1});
            tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("single_drained", {63'd0, wb_valid}, 64'd0);
        wait_idle();

        // Fill the queue while the divider is held busy, then drain in order.
        hold_active = 1'b1;
        push(32'h3F800000, 32'h40000000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 32'h3F000000);
        push(32'h40800000, 32'h40000000, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'h40000000);
        push(32'h40800000, 32'h00000000, 1'b1, 2'd2, 2'd2, 1'b1, 1'b1, 32'h40000000);
        push(32'h41000000, 32'h40000000, 1'b0, 2'd3, 2'd3, 1'b1, 1'b1, 32'h40800000);
        enq_valid = 1'b1; enq_a = 32'h40000000; enq_b = 32'h3F800000; enq_is_sqrt = 1'b0;
        enq_rob_ptr = 2'd0; enq_dst_ptr = 2'd1;
        for (int i = 0; i < 3; i++) begin
            chk("full_enq_ready", {62'd0, enq_ready, fu_start}, 64'd0);
            tick();
        end
        hold_active = 1'b0;
        push(32'h40000000, 32'h3F800000, 1'b0, 2'd0, 2'd1, 1'b1, 1'b1, 32'h40000000);
        wait_idle();

        // Writeback backpressure blocks the next launch and keeps data stable.
        wb_ready = 1'b0;
        push(32'h40800000, 32'h40000000, 1'b0, 2'd1, 2'd2, 1'b1, 1'b1, 32'h40000000);
        push(32'h41100000, 32'h00000000, 1'b1, 2'd2, 2'd3, 1'b1, 1'b1, 32'h40400000);
        wait_sig("bp_wb_wait", 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_stall", {26'd0, fu_start, wb_valid, wb_y, wb_rob_ptr, wb_dst_ptr}, {26'd1, 32'h40000000, 2'd1, 2'd2});
            tick();
        end
        wb_ready = 1'b1;
        tick();
        chk("bp_next_launch", {63'd0, fu_start}, 64'd1);
        wait_idle();

        // Flush with an op in flight and another queued: result is discarded.
        push(32'h3F800000, 32'h40000000, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 32'h0);
        push(32'h40800000, 32'h40000000, 1'b0, 2'd3, 2'd1, 1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy_wait", {63'd0, busy}, 64'd1);
        wait_sig("flush_fu_valid", 1'b0);
        tick();
        chk("flush_dropped", {62'd0, wb_valid, busy}, 64'd0);
        wait_idle();

        // Flush coincident with a push and with the returning result.
        push(32'h41000000, 32'h40000000, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0, 32'h0);
        wait_sig("coinc_fu_valid", 1'b0);
        flush = 1'b1;
        enq_valid = 1'b1; enq_a = 32'h40000000; enq_b = 32'h3F800000; enq_rob_ptr = 2'd3; enq_dst_ptr = 2'd3;
        tick();
        flush = 1'b0; enq_valid = 1'b0;
        chk("coinc_no_capture", {61'd0, wb_valid, busy, fu_start}, 64'd0);
        wait_idle();
        push(32'h40000000, 32'h3F800000, 1'b0, 2'd2, 2'd2, 1'b1, 1'b1, 32'h40000000);
        wait_idle();

        // Asynchronous reset in the middle of an op with three entries queued.
        push(32'h3F800000, 32'h40000000, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0);
        push(32'h40800000, 32'h40000000, 1'b0, 2'd1, 2'd1, 1'b0, 1'b0, 32'h0);
        push(32'h41000000, 32'h40000000, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 32'h0);
        push(32'h40000000, 32'h3F800000, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        reset_checks("midreset");
        launch_q.delete();
        res_q.delete();
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        push(32'h3F800000, 32'h40000000, 1'b0, 2'd1, 2'd1, 1'b1, 1'b1, 32'h3F000000);
        chk("post_reset_latency", {63'd0, fu_start}, 64'd1);
        wait_idle();

        repeat (4) tick();
        chk("launch_q_empty", 64'(launch_q.size()), 64'd0);
        chk("res_q_empty", 64'(res_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
